// File: rtl/inst_decode_pkg.sv
// Shared opcode constants, control-field encodings and the decoded control word
// for the decode stage.
package inst_decode_pkg;

  localparam logic [6:0] OpMova = 7'b0000000;
  localparam logic [6:0] OpInc  = 7'b0000001;
  localparam logic [6:0] OpAdd  = 7'b0000010;
  localparam logic [6:0] OpSub  = 7'b0000101;
  localparam logic [6:0] OpDec  = 7'b0000110;
  localparam logic [6:0] OpAnd  = 7'b0001000;
  localparam logic [6:0] OpOr   = 7'b0001001;
  localparam logic [6:0] OpXor  = 7'b0001010;
  localparam logic [6:0] OpNot  = 7'b0001011;
  localparam logic [6:0] OpMovb = 7'b0001100;
  localparam logic [6:0] OpShr  = 7'b0001101;
  localparam logic [6:0] OpShl  = 7'b0001110;
  localparam logic [6:0] OpAdi  = 7'b1000010;
  localparam logic [6:0] OpLdi  = 7'b1001100;
  localparam logic [6:0] OpLd   = 7'b0010000;
  localparam logic [6:0] OpSt   = 7'b0100000;
  localparam logic [6:0] OpBrz  = 7'b1100000;
  localparam logic [6:0] OpBrn  = 7'b1100001;
  localparam logic [6:0] OpJmp  = 7'b1110000;

  typedef enum logic [3:0] {
    FsMova = 4'b0000,
    FsInc  = 4'b0001,
    FsAdd  = 4'b0010,
    FsSub  = 4'b0101,
    FsDec  = 4'b0110,
    FsAnd  = 4'b1000,
    FsOr   = 4'b1001,
    FsXor  = 4'b1010,
    FsNot  = 4'b1011,
    FsMovb = 4'b1100,
    FsShr  = 4'b1101,
    FsShl  = 4'b1110
  } fs_e;

  typedef enum logic [1:0] {
    BsInc = 2'b00,
    BsBr  = 2'b01,
    BsJmp = 2'b10
  } bs_e;

  typedef enum logic [1:0] {
    MdFunc = 2'b00,
    MdMem  = 2'b01
  } md_e;

  typedef struct packed {
    logic mb;
    fs_e  fs;
    md_e  md;
    logic rw;
    logic mw;
    bs_e  bs;
    logic ps;
    logic ill;
  } ctrl_word_t;

endpackage

// File: rtl/inst_decode_comb.sv
// Pure opcode decoder: control word plus source-register usage flags.
module inst_decode_comb
  import inst_decode_pkg::*;
#(
  parameter int unsigned OPW = 7
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_word_t     ctrl,
  output logic           uses_a,
  output logic           uses_b
);

  logic b_op;

  always_comb begin
    ctrl   = '0;
    uses_a = 1'b1;
    b_op   = 1'b0;
    unique case (opcode)
      OPW'(OpMova): begin ctrl.fs = FsMova; ctrl.rw = 1'b1; end
      OPW'(OpInc):  begin ctrl.fs = FsInc;  ctrl.rw = 1'b1; end
      OPW'(OpAdd):  begin ctrl.fs = FsAdd;  ctrl.rw = 1'b1; b_op = 1'b1; end
      OPW'(OpSub):  begin ctrl.fs = FsSub;  ctrl.rw = 1'b1; b_op = 1'b1; end
      OPW'(OpDec):  begin ctrl.fs = FsDec;  ctrl.rw = 1'b1; end
      OPW'(OpAnd):  begin ctrl.fs = FsAnd;  ctrl.rw = 1'b1; b_op = 1'b1; end
      OPW'(OpOr):   begin ctrl.fs = FsOr;   ctrl.rw = 1'b1; b_op = 1'b1; end
      OPW'(OpXor):  begin ctrl.fs = FsXor;  ctrl.rw = 1'b1; b_op = 1'b1; end
      OPW'(OpNot):  begin ctrl.fs = FsNot;  ctrl.rw = 1'b1; end
      OPW'(OpMovb): begin ctrl.fs = FsMovb; ctrl.rw = 1'b1; b_op = 1'b1; uses_a = 1'b0; end
      OPW'(OpShr):  begin ctrl.fs = FsShr;  ctrl.rw = 1'b1; b_op = 1'b1; uses_a = 1'b0; end
      OPW'(OpShl):  begin ctrl.fs = FsShl;  ctrl.rw = 1'b1; b_op = 1'b1; uses_a = 1'b0; end
      OPW'(OpAdi):  begin ctrl.fs = FsAdd;  ctrl.rw = 1'b1; ctrl.mb = 1'b1; end
      OPW'(OpLdi):  begin ctrl.fs = FsMovb; ctrl.rw = 1'b1; ctrl.mb = 1'b1; uses_a = 1'b0; end
      OPW'(OpLd):   begin ctrl.md = MdMem;  ctrl.rw = 1'b1; end
      OPW'(OpSt):   begin ctrl.mw = 1'b1;   b_op = 1'b1; end
      OPW'(OpBrz):  begin ctrl.bs = BsBr; end
      OPW'(OpBrn):  begin ctrl.bs = BsBr;   ctrl.ps = 1'b1; end
      OPW'(OpJmp):  begin ctrl.bs = BsJmp; end
      // Unknown opcodes become a NOP that reads nothing, so they can never stall.
      default:      begin ctrl.ill = 1'b1;  uses_a = 1'b0; end
    endcase
    uses_b = b_op && !ctrl.mb;
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered decode stage: valid/ready pipeline register, per-register pending
// scoreboard and RAW hazard stall.
module inst_decode_stage
  import inst_decode_pkg::*;
#(
  parameter int unsigned RAW = 3,
  parameter int unsigned OPW = 7,
  parameter int unsigned IW  = OPW + 3 * RAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_inst,
  input  logic           flush,
  input  logic           wb_valid,
  input  logic [RAW-1:0] wb_addr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RAW-1:0] DA,
  output logic [RAW-1:0] AA,
  output logic [RAW-1:0] BA,
  output logic           MB,
  output logic [RAW-1:0] IMM,
  output logic [3:0]     FS,
  output logic [1:0]     MD,
  output logic           RW,
  output logic           MW,
  output logic [1:0]     BS,
  output logic           PS,
  output logic           ILL
);

  localparam int unsigned NReg = 2 ** RAW;

  logic [OPW-1:0] opcode;
  logic [RAW-1:0] dr, sa, sb;
  ctrl_word_t     ctrl_dec;
  logic           uses_a, uses_b;

  ctrl_word_t     ctrl_q;
  logic [RAW-1:0] da_q, aa_q, ba_q;
  logic           out_valid_q;
  logic [NReg-1:0] pend_q, pend_d, pend_eff, wb_mask, set_mask;
  logic           haz, accept, out_fire;

  assign opcode = in_inst[IW-1 -: OPW];
  assign dr     = in_inst[3*RAW-1 -: RAW];
  assign sa     = in_inst[2*RAW-1 -: RAW];
  assign sb     = in_inst[RAW-1:0];

  inst_decode_comb #(
    .OPW (OPW)
  ) u_comb (
    .opcode (opcode),
    .ctrl   (ctrl_dec),
    .uses_a (uses_a),
    .uses_b (uses_b)
  );

  // A writeback clear is applied before the hazard check so a stalled reader
  // can issue in the same cycle the result lands.
  assign wb_mask  = wb_valid ? (NReg'(1) << wb_addr) : '0;
  assign pend_eff = pend_q & ~wb_mask;
  assign out_fire = out_valid_q && out_ready;
  assign set_mask = (out_fire && ctrl_q.rw) ? (NReg'(1) << da_q) : '0;
  assign pend_d   = pend_eff | set_mask;

  assign haz      = (uses_a && pend_eff[sa]) || (uses_b && pend_eff[sb]);
  assign in_ready = !rst && !flush && !haz && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      da_q        <= '0;
      aa_q        <= '0;
      ba_q        <= '0;
      pend_q      <= '0;
    end else begin
      pend_q <= pend_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        ctrl_q      <= ctrl_dec;
        da_q        <= dr;
        aa_q        <= sa;
        ba_q        <= sb;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign DA        = da_q;
  assign AA        = aa_q;
  assign BA        = ba_q;
  assign IMM       = ba_q;
  assign MB        = ctrl_q.mb;
  assign FS        = ctrl_q.fs;
  assign MD        = ctrl_q.md;
  assign RW        = ctrl_q.rw;
  assign MW        = ctrl_q.mw;
  assign BS        = ctrl_q.bs;
  assign PS        = ctrl_q.ps;
  assign ILL       = ctrl_q.ill;

endmodule
